// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern transmitter, MSB-first, with repeat and gap
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   start     begin a transmission (only honoured while idle)
//   pattern   PAT_W-bit pattern, sent MSB first, latched on accepted start
//   repeat_n  extra repetitions (total = repeat_n+1), latched on accepted start
//   gap       idle cycles between repetitions, latched on accepted start
//   out       serial data bit
//   valid     out carries a pattern bit
//   busy      transmission in progress
//   done      one-cycle pulse after the final bit
module seq_pattern_gen #(
    parameter int PAT_W = 5,
    parameter int REP_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(PAT_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [BW-1:0]    IDX_TOP = BW'(PAT_W - 1);
    localparam logic [BW-1:0]    IDX_ONE = BW'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_reg;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_cnt;
    // bit_idx is the index of the bit currently on out while in SEND
    logic [BW-1:0]    bit_idx;
    logic [BW-1:0]    next_idx;

    always_comb begin
        next_idx = bit_idx - IDX_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pat_reg <= '0;
            rep_cnt <= '0;
            gap_reg <= '0;
            gap_cnt <= '0;
            bit_idx <= '0;
            out     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    out   <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        pat_reg <= pattern;
                        rep_cnt <= repeat_n;
                        gap_reg <= gap;
                        gap_cnt <= '0;
                        bit_idx <= IDX_TOP;
                        out     <= pattern[PAT_W-1];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (bit_idx != '0) begin
                        bit_idx <= next_idx;
                        out     <= pat_reg[next_idx];
                    end else if (rep_cnt == '0) begin
                        // Last bit of the last repetition has just been driven
                        state <= S_IDLE;
                        out   <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_reg == '0) begin
                        // Back-to-back: next MSB follows the LSB with no bubble
                        rep_cnt <= rep_cnt - REP_ONE;
                        bit_idx <= IDX_TOP;
                        out     <= pat_reg[PAT_W-1];
                    end else begin
                        rep_cnt <= rep_cnt - REP_ONE;
                        gap_cnt <= gap_reg;
                        out     <= 1'b0;
                        valid   <= 1'b0;
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    // gap_cnt counts the idle cycles still to be shown, including this one
                    if (gap_cnt <= GAP_ONE) begin
                        gap_cnt <= '0;
                        bit_idx <= IDX_TOP;
                        out     <= pat_reg[PAT_W-1];
                        valid   <= 1'b1;
                        state   <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    out   <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] pattern;
    logic [3:0] repeat_n;
    logic [2:0] gap;
    logic       out;
    logic       valid;
    logic       busy;
    logic       done;

    int checks;
    int fails;

    seq_pattern_gen #(
        .PAT_W(5),
        .REP_W(4),
        .GAP_W(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .repeat_n(repeat_n),
        .gap     (gap),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk a stream starting at its first bit cycle; stops in the done cycle.
    // outs/vals hold the expected bits with the first cycle at index n-1.
    // When inject is set, a start with a different pattern is pulsed mid-stream.
    task automatic run_stream(input string tag, input int n, input logic [31:0] outs,
                              input logic [31:0] vals, input bit inject);
        for (int i = n - 1; i >= 0; i--) begin
            check_eq($sformatf("%s out[%0d]", tag, i), {31'd0, out}, {31'd0, outs[i]});
            check_eq($sformatf("%s valid[%0d]", tag, i), {31'd0, valid}, {31'd0, vals[i]});
            check_eq($sformatf("%s busy/done[%0d]", tag, i), {30'd0, busy, done}, 32'd2);
            if (inject && i == n - 3) begin
                start    = 1'b1;
                pattern  = 5'b11111;
                repeat_n = 4'd0;
                gap      = 3'd0;
            end
            if (inject && i == n - 4) start = 1'b0;
            tick();
        end
        check_eq($sformatf("%s done cycle", tag), {28'd0, out, valid, busy, done}, 32'b0001);
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        rst      = 1'b0;
        start    = 1'b1;
        pattern  = 5'b10101;
        repeat_n = 4'd0;
        gap      = 3'd0;

        // Reset held with start asserted: everything stays quiet
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("reset cyc%0d", i), {28'd0, out, valid, busy, done}, 32'b0000);
        end

        // Single shot, start accepted on the first edge with rst=1
        rst = 1'b1;
        tick();
        start = 1'b0;
        run_stream("single", 5, 32'b10101, 32'b11111, 1'b0);
        tick();
        check_eq("single after done", {28'd0, out, valid, busy, done}, 32'b0000);

        // Overlapping burst, no gap
        pattern  = 5'b10101;
        repeat_n = 4'd1;
        gap      = 3'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        run_stream("burst", 10, 32'b1010110101, 32'b1111111111, 1'b0);
        tick();
        check_eq("burst after done", {28'd0, out, valid, busy, done}, 32'b0000);

        // Gapped repeat with a start/pattern change injected mid-stream
        pattern  = 5'b10101;
        repeat_n = 4'd2;
        gap      = 3'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        run_stream("gapped", 19, 32'b1010100101010010101, 32'b1111100111110011111, 1'b1);
        // The ignored start must not launch a job now
        tick();
        check_eq("gapped after done", {28'd0, out, valid, busy, done}, 32'b0000);
        tick();
        check_eq("gapped idle2", {28'd0, out, valid, busy, done}, 32'b0000);

        // Abort mid-pattern
        pattern  = 5'b11011;
        repeat_n = 4'd3;
        gap      = 3'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check_eq("abort bit0", {28'd0, out, valid, busy, done}, 32'b1110);
        tick();
        check_eq("abort bit1", {28'd0, out, valid, busy, done}, 32'b1110);
        rst = 1'b0;
        tick();
        check_eq("abort reset", {28'd0, out, valid, busy, done}, 32'b0000);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("abort idle%0d", i), {28'd0, out, valid, busy, done}, 32'b0000);
        end

        // Back-to-back: start raised in the done cycle
        pattern  = 5'b11001;
        repeat_n = 4'd0;
        gap      = 3'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        run_stream("b2b first", 5, 32'b11001, 32'b11111, 1'b0);
        pattern = 5'b01110;
        start   = 1'b1;
        tick();
        start = 1'b0;
        run_stream("b2b second", 5, 32'b01110, 32'b11111, 1'b0);
        tick();
        check_eq("b2b after done", {28'd0, out, valid, busy, done}, 32'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
